// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard.
// It keeps one countdown per architectural register. A nonzero count means
// the register's result is not yet available through forwarding. When the
// instruction in ID reads a busy register, the block raises stall.
// Optional macro HAZARD_STALL_COUNT_EN: when defined, stallCount counts the
// cycles in which stall was high. When it is undefined, stallCount is tied
// to zero.
module hazard_scoreboard #(
    parameter int NREG    = 32,
    parameter int REG_W   = 5,
    parameter int MAX_LAT = 4,
    localparam int LAT_W  = $clog2(MAX_LAT + 1)
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             issueValid,
    input  logic             issueWrite,
    input  logic [REG_W-1:0] issueReg,
    input  logic [LAT_W-1:0] issueLat,
    input  logic             flush,
    input  logic [REG_W-1:0] idRs,
    input  logic [REG_W-1:0] idRt,
    input  logic             idUseRs,
    input  logic             idUseRt,
    output logic             stall,
    output logic [NREG-1:0]  busyMask,
    output logic [31:0]      stallCount
);

    // Per-register countdown of cycles until the result can be forwarded.
    logic [LAT_W-1:0] cnt_q [NREG];

    logic issue_ok;
    logic load_any;

    // The dependency check reads only the pre-edge counts. This lets an
    // instruction write its own source register without stalling on itself.
    always_comb begin
        stall = (idUseRs && (idRs != '0) && (cnt_q[idRs] != '0)) ||
                (idUseRt && (idRt != '0) && (cnt_q[idRt] != '0));
    end

    // A flushed or stalled instruction never reaches EX, so it must not claim
    // its destination register.
    assign issue_ok = issueValid && !stall && !flush;
    assign load_any = issue_ok && issueWrite && (issueReg != '0) && (issueLat != '0);

    for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
        logic             load_en;
        logic [LAT_W-1:0] cnt_d;

        assign load_en = load_any && (issueReg == REG_W'(gi));

        // A new producer overrides the countdown. Otherwise the count decays
        // to zero.
        always_comb begin
            cnt_d = cnt_q[gi];
            if (load_en) begin
                cnt_d = issueLat;
            end else if (cnt_q[gi] != '0) begin
                cnt_d = cnt_q[gi] - LAT_W'(1);
            end
        end

        // Countdown storage. Reset discards every in-flight producer.
        always_ff @(posedge clk or negedge resetN) begin
            if (!resetN) begin
                cnt_q[gi] <= '0;
            end else begin
                cnt_q[gi] <= cnt_d;
            end
        end

        assign busyMask[gi] = (cnt_q[gi] != '0);
    end

`ifdef HAZARD_STALL_COUNT_EN
    logic [31:0] stall_cnt_q;

    // Free-running count of stalled cycles. It wraps naturally at 2**32.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            stall_cnt_q <= '0;
        end else if (stall) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stallCount = stall_cnt_q;
`else
    assign stallCount = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard.
// Each table row describes one ID cycle. The row gives the inputs and the
// outputs expected during that cycle, before the closing edge.
module tb_hazard_scoreboard;

    localparam int MAX_LAT = 4;

    logic        clk;
    logic        resetN;
    logic        issueValid;
    logic        issueWrite;
    logic [4:0]  issueReg;
    logic [2:0]  issueLat;
    logic        flush;
    logic [4:0]  idRs;
    logic [4:0]  idRt;
    logic        idUseRs;
    logic        idUseRt;
    logic        stall;
    logic [31:0] busyMask;
    logic [31:0] stallCount;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        iv;
        logic        iw;
        logic [4:0]  ireg;
        logic [2:0]  ilat;
        logic        fl;
        logic        urs;
        logic [4:0]  rs;
        logic        urt;
        logic [4:0]  rt;
        logic        es;
        logic [31:0] eb;
        int          ec;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];

    hazard_scoreboard dut (
        .clk        (clk),
        .resetN     (resetN),
        .issueValid (issueValid),
        .issueWrite (issueWrite),
        .issueReg   (issueReg),
        .issueLat   (issueLat),
        .flush      (flush),
        .idRs       (idRs),
        .idRt       (idRt),
        .idUseRs    (idUseRs),
        .idUseRt    (idUseRt),
        .stall      (stall),
        .busyMask   (busyMask),
        .stallCount (stallCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(logic iv, logic iw, logic [4:0] ireg, logic [2:0] ilat,
                                logic fl, logic urs, logic [4:0] rs, logic urt,
                                logic [4:0] rt, logic es, logic [31:0] eb, int ec);
        vec_t v;
        v.iv = iv; v.iw = iw; v.ireg = ireg; v.ilat = ilat; v.fl = fl;
        v.urs = urs; v.rs = rs; v.urt = urt; v.rt = rt;
        v.es = es; v.eb = eb; v.ec = ec;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        issueValid = v.iv; issueWrite = v.iw; issueReg = v.ireg; issueLat = v.ilat;
        flush = v.fl; idUseRs = v.urs; idRs = v.rs; idUseRt = v.urt; idRt = v.rt;
    endtask

    function automatic int exp_count(int c);
`ifdef HAZARD_STALL_COUNT_EN
        return c;
`else
        return 0;
`endif
    endfunction

    initial begin
        vec_t v;
        vec_t e;

        resetN = 1'b0;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        // Table columns: iv iw reg lat fl | urs rs urt rt | stall busy count
        // Load-use: one stall cycle.
        tbl.push_back(mk(1, 1,  8, 1, 0, 0,  0, 0,  0, 0, 32'h0,    0));
        tbl.push_back(mk(1, 1, 10, 0, 0, 1,  8, 0,  0, 1, 32'h100,  0));
        tbl.push_back(mk(1, 1, 10, 0, 0, 1,  8, 0,  0, 0, 32'h0,    1));
        // Latency 4 on rt: four stall cycles.
        tbl.push_back(mk(1, 1,  9, 4, 0, 0,  0, 0,  0, 0, 32'h0,    1));
        tbl.push_back(mk(1, 1, 11, 0, 0, 0,  0, 1,  9, 1, 32'h200,  1));
        tbl.push_back(mk(1, 1, 11, 0, 0, 0,  0, 1,  9, 1, 32'h200,  2));
        tbl.push_back(mk(1, 1, 11, 0, 0, 0,  0, 1,  9, 1, 32'h200,  3));
        tbl.push_back(mk(1, 1, 11, 0, 0, 0,  0, 1,  9, 1, 32'h200,  4));
        tbl.push_back(mk(1, 1, 11, 0, 0, 0,  0, 1,  9, 0, 32'h0,    5));
        // WAW: a newer short-latency writer overrides the older one.
        tbl.push_back(mk(1, 1,  5, 4, 0, 0,  0, 0,  0, 0, 32'h0,    5));
        tbl.push_back(mk(1, 1,  5, 1, 0, 0,  0, 0,  0, 0, 32'h20,   5));
        tbl.push_back(mk(0, 0,  0, 0, 0, 0,  0, 0,  0, 0, 32'h20,   5));
        tbl.push_back(mk(0, 0,  0, 0, 0, 0,  0, 0,  0, 0, 32'h0,    5));
        // r0 is never busy, and a flushed issue claims nothing.
        tbl.push_back(mk(1, 1,  0, 3, 0, 0,  0, 0,  0, 0, 32'h0,    5));
        tbl.push_back(mk(0, 0,  0, 0, 0, 0,  0, 0,  0, 0, 32'h0,    5));
        tbl.push_back(mk(1, 1,  7, 2, 1, 1,  7, 0,  0, 0, 32'h0,    5));
        tbl.push_back(mk(0, 0,  0, 0, 0, 1,  7, 0,  0, 0, 32'h0,    5));
        // An instruction does not stall on its own destination.
        tbl.push_back(mk(1, 1, 12, 2, 0, 1, 12, 0,  0, 0, 32'h0,    5));
        tbl.push_back(mk(0, 0,  0, 0, 0, 0,  0, 0,  0, 0, 32'h1000, 5));
        tbl.push_back(mk(0, 0,  0, 0, 0, 0,  0, 0,  0, 0, 32'h1000, 5));
        tbl.push_back(mk(0, 0,  0, 0, 0, 0,  0, 0,  0, 0, 32'h0,    5));
        // Flush keeps the older pending producer alive.
        tbl.push_back(mk(1, 1, 13, 3, 0, 0,  0, 0,  0, 0, 32'h0,    5));
        tbl.push_back(mk(1, 1, 14, 2, 1, 0,  0, 0,  0, 0, 32'h2000, 5));
        tbl.push_back(mk(0, 0,  0, 0, 0, 0,  0, 1, 13, 1, 32'h2000, 5));
        tbl.push_back(mk(0, 0,  0, 0, 0, 0,  0, 1, 13, 1, 32'h2000, 6));
        tbl.push_back(mk(0, 0,  0, 0, 0, 0,  0, 1, 13, 0, 32'h0,    7));

        // Reset state.
        #12;
        chk("reset_busy", busyMask, 32'h0);
        chk("reset_stall", {31'd0, stall}, 32'h0);
        chk("reset_count", stallCount, 32'h0);
        @(negedge clk);
        resetN = 1'b1;

        // Table replay: the expected row is queued when driven and popped at sample time.
        for (int i = 0; i < tbl.size(); i++) begin
            v = tbl[i];
            @(negedge clk);
            if (v.ilat > MAX_LAT) begin
                total++;
                bad++;
                $display("FAIL illegal_lat row %0d: got %0d limit %0d", i, v.ilat, MAX_LAT);
            end
            drive(v);
            exp_q.push_back(v);
            #2;
            e = exp_q.pop_front();
            chk($sformatf("row%0d_stall", i), {31'd0, stall}, {31'd0, e.es});
            chk($sformatf("row%0d_busy", i), busyMask, e.eb);
            chk($sformatf("row%0d_count", i), stallCount, 32'(exp_count(e.ec)));
        end

        // Reset in the middle of a countdown.
        @(negedge clk);
        drive(mk(1, 1, 3, 3, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        drive(mk(0, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0, 0));
        #2;
        chk("prerst_busy", busyMask, 32'h8);
        chk("prerst_stall", {31'd0, stall}, 32'h1);
        #1 resetN = 1'b0;
        #1;
        chk("midrst_busy", busyMask, 32'h0);
        chk("midrst_stall", {31'd0, stall}, 32'h0);
        chk("midrst_count", stallCount, 32'h0);
        @(negedge clk);
        resetN = 1'b1;
        drive(mk(1, 1, 4, 0, 0, 1, 3, 0, 0, 0, 0, 0));
        #2;
        chk("postrst_stall", {31'd0, stall}, 32'h0);
        chk("postrst_busy", busyMask, 32'h0);
        @(negedge clk);
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #2;
        chk("postrst_busy2", busyMask, 32'h0);
        chk("postrst_count", stallCount, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
